pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Generates the per-stage `_en` and `_flush` strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC write enable. It also handles:
- load-use bubbles;
- branch/jump squashes, including redirects that arrive while fetch is stalled;
- data-memory completion that arrives before instruction fetch completes;
- halt.

It sits beside the datapath. It drives only control strobes and never touches pipeline data.

## Interface
Parameters:
- `CNT_W`, 16: width of the saturating performance counters.

Ports:
- `CLK`  in  1  pipeline clock; all state updates on rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `ihit`  in  1  instruction fetch complete this cycle.
- `dhit`  in  1  data access complete this cycle.
- `ifid_rs`, `ifid_rt`  in  5 each  source registers of the instruction in ID.
- `idex_dREN`  in  1  instruction in EX is a load.
- `idex_dest`  in  5  destination register of the instruction in EX.
- `exmem_dREN`, `exmem_dWEN`  in  1 each  instruction in MEM issues a data access.
- `redirect`  in  1  one-cycle pulse; a branch was taken or a jump resolved in EX.
- `halt_mem`  in  1  halt instruction is in MEM.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  stage register / PC load enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1 each  synchronous clear; qualified here, and a register honours it only when its `_en` is also high.
- `dmem_mask`  out  1  suppresses the dREN/dWEN request to memory.
- `halt_out`  out  1  processor halted.
- `stall_cnt`  out  CNT_W  count of cycles in which the pipeline did not advance.
- `flush_cnt`  out  CNT_W  count of redirects applied.

## Operation
Derived terms, all combinational:
- `mem_req = (exmem_dREN | exmem_dWEN) & ~dmem_mask`.
- `dstall = mem_req & ~dhit`.
- `advance = ihit & ~dstall & (state != HALT)`.
- `load_use = idex_dREN & (idex_dest != 0) & ((idex_dest == ifid_rs) | (idex_dest == ifid_rt))`.
- `squash = redirect | pend`.

FSM states are `RUN`, `DDONE` and `HALT`. The registered flag `pend` sits alongside the FSM.

State transitions:
- `RUN` → `DDONE` when `mem_req & dhit & ~ihit`. The data is done but fetch is not; the access must not be reissued.
- `DDONE` → `RUN` when `advance`. While in `DDONE`, `dmem_mask` = 1.
- `RUN` or `DDONE` → `HALT` when `halt_mem & advance`.
- `HALT` is sticky and exits only on reset.

`pend` behaviour:
- Set on `redirect & ~advance`.
- Cleared on `advance`.
- If set and cleared in the same cycle, clear wins; the squash is applied on that advance.

Strobes when `advance` = 1, in priority order:
1. If `squash`: `pc_en` = 1, `ifid_flush` = 1, `idex_flush` = 1, and all `_en` = 1.
2. Else if `load_use`: `pc_en` = 0, `ifid_en` = 0, `idex_en` = 1, `idex_flush` = 1 (one bubble), `exmem_en` = 1, `memwb_en` = 1.
3. Else: all `_en` = 1, and all `_flush` = 0.

Strobes when `advance` = 0: all `_en` = 0 and all `_flush` = 0.

Other rules:
- `exmem_flush` and `memwb_flush` are always 0. They are reserved outputs.
- `halt_out` = 1 exactly when `state == HALT`.

Counters:
- `stall_cnt` increments when `~advance` and `state != HALT`.
- `flush_cnt` increments on `advance & squash`.
- Both saturate at all-ones and never wrap.

## Timing
Output timing:
- All strobes are Mealy outputs: combinational from state, `pend` and the current inputs.
- The pipeline registers sample them at the same rising edge.
- Latency from input to strobe is zero cycles.
- A load-use hazard costs exactly one bubble cycle when `ihit` = 1.

Reset (`nRST` low, asynchronous):
- `state` = `RUN`, `pend` = 0, and both counters = 0.
- All `_en` and `_flush` are forced to 0, as are `dmem_mask` and `halt_out`, independent of the inputs.

Reset mid-stall clears `pend` and `DDONE`; the datapath restarts from its own reset PC.

Simultaneous events:
- `redirect` together with `load_use`: the squash wins and no bubble is inserted, because the ID instruction is killed anyway.
- `redirect` while `dstall`: the redirect is latched in `pend` and applied on the first advance.
- `halt_mem` together with `squash` on advance: the transition to `HALT` still occurs.

`dhit` arriving in `DDONE` is ignored, because `mem_req` is masked.

## Structure
- `ctrl_state_t`, an enum of `RUN`, `DDONE` and `HALT`, goes in `cpu_types_pkg`.
- `load_use` is produced in sub-module `hazard_detect`, which is purely combinational.
- The FSM, `pend` and the counters live in the top-level module.

## Test plan
- **Reset:** `nRST` low with `ihit` = 1 → all strobes 0, counters 0. After release with `ihit` = 1 → all `_en` = 1 next cycle.
- **Load-use:** `idex_dREN` = 1, `idex_dest` = 8, `ifid_rs` = 8, `ihit` = 1 → one cycle with `pc_en` = 0, `ifid_en` = 0, `idex_flush` = 1, and `stall_cnt` unchanged. With `idex_dest` = 0 there is no bubble.
- **Redirect while `ihit` = 0:** then `ihit` = 1 three cycles later → `pend` holds for those cycles, `ifid_flush` = 1 and `idex_flush` = 1 on the advance cycle, `flush_cnt` = 1, `stall_cnt` = 3.
- **Data before fetch:** `exmem_dREN` = 1, `dhit` = 1, `ihit` = 0 → next cycle `state` = `DDONE`, `dmem_mask` = 1. On `ihit` = 1 → advance and return to `RUN` with `dmem_mask` = 0.
- **Halt:** `halt_mem` = 1 with advance → `halt_out` = 1 from the next cycle. Later `ihit` pulses keep all `_en` = 0; only `nRST` clears it.
- **Saturation:** force `CNT_W` = 4 and stall 20 cycles → `stall_cnt` = 15 and stays at 15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types and helpers for the pipeline control path.
// Holds the sequencer state encoding and the register-compare used by hazard detection.
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DDONE = 2'd1,
        HALT  = 2'd2
    } ctrl_state_t;

    // A load into r0 never creates a dependency, since r0 is hardwired to zero.
    function automatic logic reg_hazard(input logic [REG_W-1:0] dest,
                                        input logic [REG_W-1:0] rs,
                                        input logic [REG_W-1:0] rt);
        return (dest != {REG_W{1'b0}}) && ((dest == rs) || (dest == rt));
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use detector.
// Flags when the instruction in ID reads the register a load in EX is about to write.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic             idex_dREN,
    input  logic [REG_W-1:0] idex_dest,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    output logic             load_use
);

    // Raw hazard flag; the sequencer decides whether it actually costs a bubble.
    always_comb begin
        load_use = 1'b0;
        if (idex_dREN) begin
            load_use = reg_hazard(idex_dest, ifid_rs, ifid_rt);
        end else begin
            load_use = 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: stage enables, squashes,
// memory-before-fetch tracking, halt, and saturating stall/flush counters.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             idex_dREN,
    input  logic [REG_W-1:0] idex_dest,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             redirect,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             dmem_mask,
    output logic             halt_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_t      r_state;
    logic             r_pend;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_load_use;
    logic w_mem_req;
    logic w_dstall;
    logic w_advance;
    logic w_squash;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    hazard_detect u_hazard (
        .idex_dREN (idex_dREN),
        .idex_dest (idex_dest),
        .ifid_rs   (ifid_rs),
        .ifid_rt   (ifid_rt),
        .load_use  (w_load_use)
    );

    // Advance/squash terms and the Mealy strobes; reset overrides every input.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        dmem_mask   = nRST && (r_state == DDONE);
        halt_out    = nRST && (r_state == HALT);
        w_mem_req   = (exmem_dREN | exmem_dWEN) & ~dmem_mask;
        w_dstall    = w_mem_req & ~dhit;
        w_advance   = ihit & ~w_dstall & (r_state != HALT);
        w_squash    = redirect | r_pend;
        if (!nRST) begin
            pc_en = 1'b0;
        end else if (w_advance && w_squash) begin
            // A squash kills ID, so a coincident load-use bubble is pointless.
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_advance && w_load_use) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00111;
            idex_flush = 1'b1;
        end else if (w_advance) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        end else begin
            pc_en = 1'b0;
        end
    end

    // Sequencer state, pending redirect and saturating counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= RUN;
            r_pend      <= 1'b0;
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                RUN: begin
                    if (halt_mem && w_advance) begin
                        r_state <= HALT;
                    end else if (w_mem_req && dhit && !ihit) begin
                        r_state <= DDONE;
                    end else begin
                        r_state <= RUN;
                    end
                end
                DDONE: begin
                    if (halt_mem && w_advance) begin
                        r_state <= HALT;
                    end else if (w_advance) begin
                        r_state <= RUN;
                    end else begin
                        r_state <= DDONE;
                    end
                end
                HALT:    r_state <= HALT;
                default: r_state <= RUN;
            endcase

            if (w_advance) begin
                r_pend <= 1'b0;
            end else if (redirect) begin
                r_pend <= 1'b1;
            end else begin
                r_pend <= r_pend;
            end

            if (!w_advance && (r_state != HALT) && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end

            if (w_advance && w_squash && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
